// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ producers onto one FIFO write port,
// with acknowledge-checked retry. Define FIFO_ARB_STATS_EN for retry/grant counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          wr_ack,
  input  logic                          overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [7:0]                    retry_cnt,
  output logic [15:0]                   grant_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic [DATA_WIDTH-1:0]  win_data_q, win_data_d;
  logic [DATA_WIDTH-1:0]  data_in_q, data_in_d;
  logic                   wr_en_q, wr_en_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;

  logic [DATA_WIDTH-1:0]  slice [NUM_REQ];
  logic [NUM_REQ-1:0]     elig;
  logic                   found;
  logic [PTR_W-1:0]       pick;
  int                     arb_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The index granted this cycle is excluded so its stale word is not re-latched.
  always_comb begin
    elig    = req & ~grant_q;
    found   = 1'b0;
    pick    = '0;
    arb_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && elig[arb_idx]) begin
        found = 1'b1;
        pick  = PTR_W'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    win_data_d = win_data_q;
    data_in_d  = data_in_q;
    wr_en_d    = 1'b0;
    grant_d    = '0;
    case (state_q)
      IDLE: begin
        if (!full && found) begin
          win_d      = pick;
          win_data_d = slice[pick];
          data_in_d  = slice[pick];
          wr_en_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = ACK;
      ACK: begin
        if (wr_ack) begin
          state_d        = IDLE;
          grant_d[win_q] = 1'b1;
          ptr_d          = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A held word owns the port until it is accepted.
        if (!full) begin
          wr_en_d   = 1'b1;
          data_in_d = win_data_q;
          state_d   = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      win_data_q <= '0;
      data_in_q  <= '0;
      wr_en_q    <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      win_data_q <= win_data_d;
      data_in_q  <= data_in_d;
      wr_en_q    <= wr_en_d;
      grant_q    <= grant_d;
    end
  end

  assign grant   = grant_q;
  assign wr_en   = wr_en_q;
  assign data_in = data_in_q;
  assign busy    = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
  logic [7:0]  retry_cnt_q, retry_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (state_q == ACK && !wr_ack && retry_cnt_q != 8'hFF)
      retry_cnt_d = retry_cnt_q + 8'd1;
    if (|grant_d && grant_cnt_q != 16'hFFFF)
      grant_cnt_d = grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign retry_cnt = retry_cnt_q;
  assign grant_cnt = grant_cnt_q;
`else
  // Flags only matter as "not acknowledged"; overflow is implied by !wr_ack.
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: small FIFO model, vector table, hand-written corner sequences.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic            wr_en;
  logic [DW-1:0]   data_in;
  logic            full;
  logic            wr_ack;
  logic            overflow;
`ifdef FIFO_ARB_STATS_EN
  logic [7:0]      retry_cnt;
  logic [15:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .full     (full),
    .wr_ack   (wr_ack),
    .overflow (overflow)
`ifdef FIFO_ARB_STATS_EN
    ,
    .retry_cnt(retry_cnt),
    .grant_cnt(grant_cnt)
`endif
  );

  // FIFO write-side model: occupancy counter with registered ack/overflow.
  int   fifo_cnt;
  logic rd_en = 1'b1;
  logic ext_wr = 1'b0;
  assign full = (fifo_cnt == DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt <= 0;
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ack   <= wr_en && !full;
      overflow <= wr_en && full;
      fifo_cnt <= fifo_cnt + ((wr_en && !full) ? 1 : 0) + ((ext_wr && !full) ? 1 : 0)
                  - ((rd_en && fifo_cnt > 0) ? 1 : 0);
    end
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the oldest expected word.
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        check("wr_en_gap", 32'(prev_wr), 32'd0);
        if (!full) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected none", data_in);
          end else begin
            check("commit_data", 32'(data_in), 32'(exp_q.pop_front()));
          end
        end
      end
      if (grant != '0) check("grant_onehot", 32'($countones(grant)), 32'd1);
    end
    prev_wr <= wr_en;
  end

  task automatic drive_slices(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string name, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no grant in 40 cycles expected %b", name, exp);
    end else begin
      $display("txn %s: grant=%b after %0d cycles", name, grant, cyc);
      check(name, 32'(grant), 32'(exp));
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   seed;
    int           exp_win;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [N-1:0] eg;

    vecs[0] = '{4'b0011, 8'h10, 0};
    vecs[1] = '{4'b0011, 8'h21, 1};
    vecs[2] = '{4'b1001, 8'h32, 3};
    vecs[3] = '{4'b1010, 8'h43, 1};
    vecs[4] = '{4'b0001, 8'h54, 0};
    vecs[5] = '{4'b1100, 8'h65, 2};
    vecs[6] = '{4'b1111, 8'h76, 3};
    vecs[7] = '{4'b0110, 8'h87, 1};
    vecs[8] = '{4'b0001, 8'h98, 0};
    vecs[9] = '{4'b1000, 8'hA9, 3};

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_data_in", 32'(data_in), 32'd0);
    end

    // Single write with exact cycle timing
    @(posedge clk); #1;
    drive_slices(16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
    req = 4'b0100;
    exp_q.push_back(16'hA5A5);
    @(negedge clk); check("single_c0_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk); check("single_c1_wr_en", 32'(wr_en), 32'd1);
    check("single_c1_data", 32'(data_in), 32'hA5A5);
    @(negedge clk); check("single_c2_wr_en", 32'(wr_en), 32'd0);
    check("single_c2_grant", 32'(grant), 32'd0);
    @(negedge clk); check("single_c3_grant", 32'(grant), 32'b0100);
    $display("txn single: grant=%b data=a5a5", grant);
    req = '0;

    // Vector table: expected winner derived from rotating priority
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {vecs[v].seed, 8'(i)};
      req = vecs[v].req;
      exp_q.push_back({vecs[v].seed, 8'(vecs[v].exp_win)});
      eg = '0;
      eg[vecs[v].exp_win] = 1'b1;
      wait_grant(eg, $sformatf("vec%0d", v), cyc);
      check("vec_latency", 32'(cyc), 32'd4);
      req = '0;
    end

    // Round-robin with all requests held
    @(posedge clk); #1;
    drive_slices(16'h0000, 16'h1111, 16'h2222, 16'h3333);
    req = 4'b1111;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h0000);
    wait_grant(4'b0001, "rr0", cyc); check("rr_lat0", 32'(cyc), 32'd4);
    wait_grant(4'b0010, "rr1", cyc); check("rr_space1", 32'(cyc), 32'd3);
    wait_grant(4'b0100, "rr2", cyc); check("rr_space2", 32'(cyc), 32'd3);
    wait_grant(4'b1000, "rr3", cyc); check("rr_space3", 32'(cyc), 32'd3);
    wait_grant(4'b0001, "rr4", cyc); check("rr_space4", 32'(cyc), 32'd3);
    req = '0;

    // Mask rule: request still high in the grant cycle
    @(posedge clk); #1;
    drive_slices(16'h0000, 16'h1234, 16'h0000, 16'h0000);
    req = 4'b0010;
    exp_q.push_back(16'h1234);
    wait_grant(4'b0010, "mask", cyc);
    @(posedge clk); #1 req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mask_no_wr_en", 32'(wr_en), 32'd0);
      check("mask_busy", 32'(busy), 32'd0);
    end

    // Overflow retry
    repeat (3) @(posedge clk);
    #1 rd_en = 1'b0; ext_wr = 1'b1;
    repeat (4) @(posedge clk);
    #1 ext_wr = 1'b0;
    drive_slices(16'hBEEF, 16'h0000, 16'h0000, 16'h0000);
    req = 4'b0001;
    exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_wr_en", 32'(wr_en), 32'd0);
      check("full_idle", 32'(busy), 32'd0);
    end
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0; ext_wr = 1'b1;
    @(posedge clk); #1 ext_wr = 1'b0;
    @(negedge clk); check("ovf_issue", 32'(wr_en), 32'd1);
    @(negedge clk); check("ovf_ack_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_wr_en", 32'(wr_en), 32'd0);
      check("hold_grant", 32'(grant), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    wait_grant(4'b0001, "retry", cyc);
    check("retry_latency", 32'(cyc), 32'd4);
    req = '0;
`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    check("retry_cnt", 32'(retry_cnt), 32'd1);
    check("grant_cnt", 32'(grant_cnt), 32'd18);
`endif

    // Reset while holding a rejected word
    @(posedge clk); #1;
    drive_slices(16'h0000, 16'h0000, 16'h7777, 16'h0000);
    req = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("full2_no_wr_en", 32'(wr_en), 32'd0);
    end
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0; ext_wr = 1'b1;
    @(posedge clk); #1 ext_wr = 1'b0;
    @(negedge clk); check("ovf2_issue", 32'(wr_en), 32'd1);
    @(negedge clk);
    @(negedge clk); check("hold2_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_data_in", 32'(data_in), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    check("midrst_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_no_wr_en", 32'(wr_en), 32'd0);
    end

    // Pointer restarts at 0 after reset
    @(posedge clk); #1;
    drive_slices(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3);
    req = 4'b1111;
    exp_q.push_back(16'hC0C0);
    wait_grant(4'b0001, "postrst_ptr", cyc);
    req = '0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the synchronous FIFO. It accepts write requests from `NUM_REQ` independent producers and serialises them onto the FIFO's single `wr_en`/`data_in` port. It confirms each write against the FIFO's registered `wr_ack`/`overflow` flags, retries any write that was rejected, and returns a one-cycle `grant` pulse to the producer whose word was committed. It sits between the producer agents and the FIFO's write side.

## Interface
- `NUM_REQ`, default 4: number of producers (2–8).
- `DATA_WIDTH`, default 16: word width; must match the FIFO `data_in` width.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-producer write request, level.
- `req_data`  in  NUM_REQ*DATA_WIDTH: per-producer word; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  NUM_REQ: one-hot, one-cycle pulse meaning "word committed to FIFO".
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `wr_en`  out  1: FIFO write enable, registered.
- `data_in`  out  DATA_WIDTH: FIFO write data, registered.
- `full`  in  1: FIFO full flag.
- `wr_ack`  in  1: FIFO write acknowledge, registered by the FIFO (valid the cycle after `wr_en`).
- `overflow`  in  1: FIFO overflow flag, same timing as `wr_ack`.

## Operation
- The FSM has four states: IDLE, ISSUE, ACK, HOLD. `ptr` (log2 NUM_REQ bits) is the highest-priority index. `win` is the latched winner index; `win_data` is the latched word.
- **IDLE**
  - If `full`=1, stay in IDLE and do not arbitrate.
  - Otherwise, if any unmasked `req` is set, pick the first set index searching from `ptr` upward, modulo NUM_REQ.
  - Latch `win` and `win_data`, then go to ISSUE.
- **Mask rule:** in the IDLE cycle that coincides with a `grant` pulse, the just-granted index is masked from arbitration. This prevents re-issuing stale data.
- **ISSUE:** drive `wr_en`=1 and `data_in`=`win_data` for exactly one cycle, then go to ACK.
- **ACK:** sample `wr_ack`/`overflow`.
  - If `wr_ack`=1: go to IDLE. `grant[win]` pulses in the next cycle. Set `ptr` = (`win`+1) mod NUM_REQ.
  - Otherwise (overflow, or neither flag set): go to HOLD. `win`, `win_data` and `ptr` are unchanged.
- **HOLD:** wait while `full`=1; when `full`=0, go to ISSUE and resend the same word. No other producer can pre-empt a held word.
- Once a word is latched, its source `req` is not re-checked. Deasserting `req` before `grant` is a protocol violation, but the word still commits and the `grant` pulse still fires.
- Producers must hold `req` and `req_data` stable until `grant`.
- At most one write is ever in flight.

## Timing
- **Reset values:** `wr_en`=0, `data_in`=0, `grant`=0, `busy`=0, state=IDLE, `ptr`=0, `win`=0, `win_data`=0. Reset is asynchronous, so assertion mid-operation clears everything immediately, including a pending or held word. Nothing is retried after reset.
- **Best case:** `req` seen in IDLE at cycle 0, `wr_en` in cycle 1, ACK in cycle 2, `grant` in cycle 3.
  - Throughput is one word per 3 cycles.
  - The next arbitration happens in the same cycle as `grant`, so back-to-back grants are 3 cycles apart.
- **Retry:** each overflow adds the HOLD time (≥1 cycle) plus ISSUE+ACK.
- `wr_en` is never high in two consecutive cycles.
- `grant` is never asserted for more than 1 cycle or on more than one bit at a time.
- **Simultaneous requests:** resolved purely by `ptr`. A producer waits at most NUM_REQ−1 grants.
- **Wrap-around:** `ptr` wraps from NUM_REQ−1 to 0.
- **Full during ISSUE:** the write is still issued. The resulting overflow is handled by HOLD.

## Configuration
- `FIFO_ARB_STATS_EN`
  - **Defined:** adds output `retry_cnt` [7:0]. It increments on every ACK→HOLD transition, saturates at 255, and resets to 0 on `rst_n`. It also adds output `grant_cnt` [15:0], which increments on every `grant` pulse, saturates at 65535, and resets to 0.
  - **Undefined:** both ports and their counters are absent. Arbitration and timing are identical either way.

## Test plan
- **Reset/idle:** `rst_n`=0 then release, with `req`=0 for 10 cycles -> `wr_en`, `grant`, `busy`, `data_in` all stay 0.
- **Single write:** `req`=4'b0100, slice2=16'hA5A5, FIFO empty -> `wr_en`=1 with `data_in`=A5A5 in cycle 1, `grant`=4'b0100 in cycle 3; the FIFO later reads out A5A5.
- **Round-robin:** `req`=4'b1111 held, data slices 0x0000/0x1111/0x2222/0x3333 -> grants in order 0,1,2,3,0 at 3-cycle spacing; FIFO contents 0000,1111,2222,3333,0000.
- **Overflow retry:** fill the FIFO to `full`, `req`=4'b0001 with data 16'hBEEF -> no `wr_en` while `full`. Then force a write in the last free cycle so `overflow`=1 -> HOLD; after one FIFO read, BEEF is re-issued and `grant`=4'b0001. With `FIFO_ARB_STATS_EN`, `retry_cnt`=1.
- **Mask rule:** only `req[1]` is high and stays high 1 cycle after its `grant` -> no second `wr_en` is issued in the grant cycle.
- **Reset mid-operation:** assert `rst_n`=0 while in HOLD -> outputs clear the same cycle; after release with `req`=0, no `wr_en` occurs.
